// File: rtl/hdsiso8_pkg.sv
// Shared definitions for the HDSISO8 shift path and its BIST sequencer.
// Holds the BIST FSM state type and the LFSR8 polynomial, output tap and
// seed, so the reference generator and LFSR8 step identically.
package hdsiso8_pkg;

  localparam int unsigned LFSR_W       = 8;
  // x^8 + x^6 + x^5 + x^4 + 1
  localparam logic [7:0]  LFSR_TAPS    = 8'b1011_1000;
  localparam int unsigned LFSR_OUT_BIT = 7;
  localparam logic [7:0]  LFSR_SEED    = 8'h01;
  localparam logic [7:0]  ERR_MAX      = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    CHECK  = 2'd2,
    REPORT = 2'd3
  } bist_state_e;

  // One Fibonacci step: shift toward the MSB, feedback parity enters at bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr8_ref.sv
// Local copy of LFSR8 used as the BIST reference bit stream.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset (state -> LFSR_SEED)
//   load_i     - load seed_i into the register (wins over en_i)
//   en_i       - advance one LFSR step
//   seed_i     - 8-bit load value
//   bit_o      - current output bit (same tap as LFSR8's LFSR_BIT)
module lfsr8_ref
  import hdsiso8_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       en_i,
  input  logic [7:0] seed_i,
  output logic       bit_o
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  // Next-state: load, step or hold
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (en_i) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign bit_o = state_q[LFSR_OUT_BIT];

endmodule

// File: rtl/siso_bist_ctrl.sv
// BIST sequencer for the HDSISO8 shift path: drives LFSR8 bits into the SISO
// chain, waits out the path latency, then compares RUN_LEN bits of D_OUT with
// a locally regenerated reference and reports a saturating error count.
// Ports:
//   CLK, RESET     - clock, asynchronous active-high reset
//   START, ABORT   - begin a run (IDLE only) / end a run early (FILL, CHECK)
//   LFSR_STATE     - live LFSR8 state, captured as reference seed on START
//   D_OUT          - SISO serial output under test
//   LFSR_EN        - LFSR8 enable (FILL, CHECK)
//   DIN_SEL        - SISO input select, 1 = LFSR bit (FILL, CHECK, REPORT)
//   BUSY           - run in progress (FILL, CHECK)
//   DONE           - one-cycle pulse in REPORT
//   PASS           - last completed run had no mismatches
//   ERR_CNT        - mismatch count, saturating at 255
module siso_bist_ctrl
  import hdsiso8_pkg::*;
#(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned RUN_LEN = 255
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       ABORT,
  input  logic [7:0] LFSR_STATE,
  input  logic       D_OUT,
  output logic       LFSR_EN,
  output logic       DIN_SEL,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [7:0] ERR_CNT
);

  localparam logic [7:0] FILL_LAST  = 8'(LATENCY - 1);
  localparam logic [7:0] CHECK_LAST = 8'(RUN_LEN - 1);

  bist_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  err_q, err_d;
  logic        pass_q, pass_d;
  logic        ref_load, ref_en, ref_bit;

  lfsr8_ref u_ref (
    .clk    (CLK),
    .rst    (RESET),
    .load_i (ref_load),
    .en_i   (ref_en),
    .seed_i (LFSR_STATE),
    .bit_o  (ref_bit)
  );

  // State and counters
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      err_q   <= 8'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state, counters and reference control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    pass_d   = pass_q;
    ref_load = 1'b0;
    ref_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d  = FILL;
          cnt_d    = 8'd0;
          err_d    = 8'd0;
          pass_d   = 1'b0;
          ref_load = 1'b1;
        end
      end
      FILL: begin
        if (ABORT) begin
          state_d = IDLE;
          pass_d  = 1'b0;
        end else if (cnt_q == FILL_LAST) begin
          state_d = CHECK;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = 8'(cnt_q + 8'd1);
        end
      end
      CHECK: begin
        if (ABORT) begin
          // Error count freezes; this cycle's compare is discarded.
          state_d = IDLE;
          pass_d  = 1'b0;
        end else begin
          ref_en = 1'b1;
          if ((D_OUT != ref_bit) && (err_q != ERR_MAX)) begin
            err_d = 8'(err_q + 8'd1);
          end
          if (cnt_q == CHECK_LAST) begin
            state_d = REPORT;
            cnt_d   = 8'd0;
            // Includes the final compare so PASS is valid alongside DONE.
            pass_d  = (err_d == 8'd0);
          end else begin
            cnt_d = 8'(cnt_q + 8'd1);
          end
        end
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the state register
  assign LFSR_EN = (state_q == FILL) || (state_q == CHECK);
  assign BUSY    = (state_q == FILL) || (state_q == CHECK);
  assign DIN_SEL = (state_q != IDLE);
  assign DONE    = (state_q == REPORT);
  assign PASS    = pass_q;
  assign ERR_CNT = err_q;

endmodule

// File: tb/tb_siso_bist_ctrl.sv
// Bench for siso_bist_ctrl: two instances (LATENCY 10 and 1), an external
// LFSR8 plus delay-line model of the SISO path, and a reference that counts
// mismatches between the observed D_OUT stream and the seeded LFSR sequence.
module tb_siso_bist_ctrl;

  localparam int RLEN     = 255;
  localparam int M_DELAY  = 0;
  localparam int M_STUCK0 = 1;
  localparam int M_INV    = 2;
  localparam int M_RAND   = 3;

  typedef struct {
    int         dut;
    int         mode;
    int         dly;
    logic [7:0] seed;
    int         abort_at;
    int         busy_start_at;
    int         exp_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start, abort, d_out;
  logic [7:0] lfsr_state [2];

  wire       en_a, sel_a, busy_a, done_a, pass_a;
  wire       en_b, sel_b, busy_b, done_b, pass_b;
  wire [7:0] err_a, err_b;

  int          errors, checks;
  logic [7:0]  env_lfsr [2];
  logic [31:0] hist [2];
  int          mode [2];
  int          dly [2];
  int          lat [2];
  vec_t        vecs [8];

  always #5 clk = ~clk;

  siso_bist_ctrl #(.LATENCY(10), .RUN_LEN(RLEN)) dut_a (
    .CLK(clk), .RESET(rst), .START(start[0]), .ABORT(abort[0]),
    .LFSR_STATE(lfsr_state[0]), .D_OUT(d_out[0]),
    .LFSR_EN(en_a), .DIN_SEL(sel_a), .BUSY(busy_a), .DONE(done_a),
    .PASS(pass_a), .ERR_CNT(err_a)
  );

  siso_bist_ctrl #(.LATENCY(1), .RUN_LEN(RLEN)) dut_b (
    .CLK(clk), .RESET(rst), .START(start[1]), .ABORT(abort[1]),
    .LFSR_STATE(lfsr_state[1]), .D_OUT(d_out[1]),
    .LFSR_EN(en_b), .DIN_SEL(sel_b), .BUSY(busy_b), .DONE(done_b),
    .PASS(pass_b), .ERR_CNT(err_b)
  );

  function automatic logic [7:0] step(input logic [7:0] s);
    return {s[6:0], ^(s & 8'hB8)};
  endfunction

  function automatic int f_en(input int i);   return int'(i == 0 ? en_a   : en_b);   endfunction
  function automatic int f_sel(input int i);  return int'(i == 0 ? sel_a  : sel_b);  endfunction
  function automatic int f_busy(input int i); return int'(i == 0 ? busy_a : busy_b); endfunction
  function automatic int f_done(input int i); return int'(i == 0 ? done_a : done_b); endfunction
  function automatic int f_pass(input int i); return int'(i == 0 ? pass_a : pass_b); endfunction
  function automatic int f_err(input int i);  return int'(i == 0 ? err_a  : err_b);  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive LFSR_STATE and D_OUT for one instance from the path model
  task automatic env_drive(input int i);
    lfsr_state[i] = env_lfsr[i];
    case (mode[i])
      M_DELAY:  d_out[i] = hist[i][dly[i]];
      M_STUCK0: d_out[i] = 1'b0;
      M_INV:    d_out[i] = ~hist[i][dly[i]];
      default:  d_out[i] = 1'($urandom_range(0, 1));
    endcase
  endtask

  // One clock: external LFSR8 steps when enabled, history records LFSR_BIT
  task automatic tick();
    logic [1:0] en_prev;
    en_prev = {en_b, en_a};
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (en_prev[i]) env_lfsr[i] = step(env_lfsr[i]);
      hist[i] = {hist[i][30:0], env_lfsr[i][7]};
      env_drive(i);
    end
  endtask

  task automatic seed_env(input int i, input logic [7:0] s, input int m, input int d);
    mode[i]     = m;
    dly[i]      = d;
    env_lfsr[i] = s;
    hist[i][0]  = s[7];
    env_drive(i);
  endtask

  task automatic run_vec(input vec_t v, input int vi);
    int         i, lt, n_end, done_edge, done_cnt, busy_cnt, model;
    logic [7:0] r;
    logic       obs [$];
    i  = v.dut;
    lt = lat[i];
    seed_env(i, v.seed, v.mode, v.dly);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
    chk($sformatf("v%0d start busy", vi), f_busy(i), 1);
    chk($sformatf("v%0d start lfsr_en", vi), f_en(i), 1);
    chk($sformatf("v%0d start din_sel", vi), f_sel(i), 1);
    chk($sformatf("v%0d start err_cnt", vi), f_err(i), 0);
    done_edge = -1;
    done_cnt  = 0;
    busy_cnt  = 1;
    n_end = (v.abort_at > 0) ? v.abort_at + 1 : lt + RLEN + 2;
    for (int n = 1; n <= n_end; n++) begin
      if (n >= lt + 1 && n <= lt + RLEN && (v.abort_at < 0 || n < v.abort_at))
        obs.push_back(d_out[i]);
      abort[i] = (n == v.abort_at);
      start[i] = (n == v.busy_start_at);
      tick();
      abort[i] = 1'b0;
      start[i] = 1'b0;
      if (f_busy(i) != 0) busy_cnt++;
      if (f_done(i) != 0) begin
        done_cnt++;
        if (done_edge < 0) done_edge = n;
      end
    end
    r = v.seed;
    model = 0;
    foreach (obs[k]) begin
      if (obs[k] != r[7]) model++;
      r = step(r);
    end
    if (model > 255) model = 255;
    if (v.abort_at < 0) begin
      chk($sformatf("v%0d done_edge", vi), done_edge, lt + RLEN);
      chk($sformatf("v%0d done_pulses", vi), done_cnt, 1);
      chk($sformatf("v%0d busy_cycles", vi), busy_cnt, lt + RLEN);
      chk($sformatf("v%0d pass", vi), f_pass(i), int'(model == 0));
    end else begin
      chk($sformatf("v%0d abort no_done", vi), done_cnt, 0);
      chk($sformatf("v%0d abort busy_cycles", vi), busy_cnt, v.abort_at);
      chk($sformatf("v%0d abort pass", vi), f_pass(i), 0);
    end
    chk($sformatf("v%0d err_cnt", vi), f_err(i), model);
    if (v.exp_err >= 0) chk($sformatf("v%0d err_cnt table", vi), f_err(i), v.exp_err);
    chk($sformatf("v%0d end lfsr_en", vi), f_en(i), 0);
    chk($sformatf("v%0d end busy", vi), f_busy(i), 0);
  endtask

  initial begin
    int   done_seen;
    vec_t rv;
    errors = 0;
    checks = 0;
    lat[0] = 10;
    lat[1] = 1;
    rst    = 1'b1;
    start  = 2'b00;
    abort  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      hist[i] = 32'd0;
      seed_env(i, 8'h01, M_DELAY, 0);
    end

    //            dut mode      dly seed   abort busy_start exp_err
    vecs[0] = '{0, M_DELAY,  10, 8'h5A, -1, -1,  0};
    vecs[1] = '{0, M_DELAY,  11, 8'h5A, -1, -1, -1};
    vecs[2] = '{0, M_STUCK0,  0, 8'h33, -1, -1, 128};
    vecs[3] = '{1, M_INV,     1, 8'hC1, -1, -1, 255};
    vecs[4] = '{1, M_DELAY,   1, 8'h01, -1, -1,  0};
    vecs[5] = '{0, M_RAND,    0, 8'h77, 15, -1, -1};
    vecs[6] = '{0, M_DELAY,  10, 8'h9E, -1, 40,  0};
    vecs[7] = '{0, M_DELAY,  10, 8'h10,  4, -1,  0};

    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset lfsr_en %0d", i), f_en(i), 0);
      chk($sformatf("reset din_sel %0d", i), f_sel(i), 0);
      chk($sformatf("reset busy %0d", i), f_busy(i), 0);
      chk($sformatf("reset done %0d", i), f_done(i), 0);
      chk($sformatf("reset pass %0d", i), f_pass(i), 0);
      chk($sformatf("reset err_cnt %0d", i), f_err(i), 0);
    end
    rst = 1'b0;
    tick();

    foreach (vecs[k]) begin
      run_vec(vecs[k], k);
      tick();
    end

    // Randomized runs against the reference model
    for (int k = 0; k < 6; k++) begin
      rv.dut           = int'($urandom_range(0, 1));
      rv.mode          = ($urandom_range(0, 1) == 0) ? M_RAND : M_DELAY;
      rv.dly           = int'($urandom_range(0, 12));
      rv.seed          = 8'($urandom_range(1, 255));
      rv.abort_at      = ($urandom_range(0, 1) == 0) ? -1
                         : int'($urandom_range(1, 255)) + lat[rv.dut] - 1;
      rv.busy_start_at = -1;
      rv.exp_err       = -1;
      run_vec(rv, 100 + k);
      tick();
    end

    // START during REPORT is ignored; START on the first IDLE cycle restarts
    seed_env(0, 8'h5A, M_STUCK0, 0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    done_seen = 0;
    for (int n = 0; n < 300 && done_seen == 0; n++) begin
      tick();
      if (done_a) done_seen = 1;
    end
    chk("report done seen", done_seen, 1);
    chk("report err_cnt", int'(err_a), 128);
    chk("report pass", int'(pass_a), 0);
    start[0] = 1'b1;
    tick();
    chk("report start ignored busy", int'(busy_a), 0);
    chk("report start err held", int'(err_a), 128);
    tick();
    start[0] = 1'b0;
    chk("idle restart busy", int'(busy_a), 1);
    chk("idle restart err cleared", int'(err_a), 0);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    chk("restart abort busy", int'(busy_a), 0);
    tick();

    // Asynchronous reset in the middle of FILL
    seed_env(0, 8'hA5, M_DELAY, 10);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    tick();
    chk("mid-fill busy before reset", int'(busy_a), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst lfsr_en", int'(en_a), 0);
    chk("async rst din_sel", int'(sel_a), 0);
    chk("async rst busy", int'(busy_a), 0);
    chk("async rst done", int'(done_a), 0);
    chk("async rst pass", int'(pass_a), 0);
    chk("async rst err_cnt", int'(err_a), 0);
    chk("async rst ref_lfsr", int'(dut_a.u_ref.state_q), 8'h01);
    tick();
    rst = 1'b0;
    tick();
    chk("post rst idle busy", int'(busy_a), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
